// File: rtl/mips_pkg.sv
// Shared MIPS constants: instruction field bit positions, the NOP encoding
// and default PC/instruction widths used by the fetch/decode stages.
package mips_pkg;

    localparam int unsigned DEF_PC_W   = 32'd32;
    localparam int unsigned DEF_INST_W = 32'd32;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_INST_C = 32'h0000_0000;

    localparam int unsigned OP_HI     = 32'd31;
    localparam int unsigned OP_LO     = 32'd26;
    localparam int unsigned RS_HI     = 32'd25;
    localparam int unsigned RS_LO     = 32'd21;
    localparam int unsigned RT_HI     = 32'd20;
    localparam int unsigned RT_LO     = 32'd16;
    localparam int unsigned RD_HI     = 32'd15;
    localparam int unsigned RD_LO     = 32'd11;
    localparam int unsigned SHAMT_HI  = 32'd10;
    localparam int unsigned SHAMT_LO  = 32'd6;
    localparam int unsigned FUNCT_HI  = 32'd5;
    localparam int unsigned FUNCT_LO  = 32'd0;
    localparam int unsigned IMM_HI    = 32'd15;
    localparam int unsigned IMM_LO    = 32'd0;
    localparam int unsigned TARGET_HI = 32'd25;
    localparam int unsigned TARGET_LO = 32'd0;

endpackage : mips_pkg

// File: rtl/if_id_skid_reg_skid_slot.sv
// One storage slot of the IF/ID skid register: a valid bit plus the PC and
// instruction it qualifies. Clear wins over load; clear only drops the valid
// bit so the data registers do not toggle needlessly.
module skid_slot #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [PC_W-1:0]   d_pc,
    input  logic [INST_W-1:0] d_inst,
    output logic              valid,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] inst
);

    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;

    // Next-state selection: clear, load, or hold
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = d_pc;
            inst_d  = d_inst;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot registers with synchronous reset to an empty, zeroed slot
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign inst  = inst_q;

endmodule : skid_slot

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register built as a 2-entry skid buffer (main + skid slot),
// so in_ready depends only on registered state. Slices the held instruction
// into MIPS decode fields; imm_16 feeds the immediate sign extender.
// Optional macro IF_ID_STALL_CNT_EN adds a free-running stall_cnt output that
// counts cycles with out_valid && !out_ready.
module if_id_skid_reg
    import mips_pkg::*;
#(
    parameter int          PC_W     = DEF_PC_W,
    parameter int          INST_W   = DEF_INST_W,
    parameter logic [31:0] NOP_INST = NOP_INST_C
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [5:0]        op,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm_16,
    output logic [25:0]       target_26
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    logic              main_valid_s, skid_valid_s;
    logic [PC_W-1:0]   main_pc_s, skid_pc_s, main_d_pc_s;
    logic [INST_W-1:0] main_inst_s, skid_inst_s, main_d_inst_s;
    logic              main_load_s, main_clear_s, main_from_skid_s;
    logic              skid_load_s, skid_clear_s;
    logic              accept_s, pop_s;

    // Handshake: in_ready is purely registered state (plus reset gating)
    assign in_ready  = !skid_valid_s && !rst;
    assign out_valid = main_valid_s && !rst;
    assign accept_s  = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Slot control: decide which slot loads, which empties, and from where
    always_comb begin
        main_load_s      = 1'b0;
        main_clear_s     = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        skid_clear_s     = 1'b0;
        if (flush) begin
            // Redirect: drop everything, including a same-cycle accept
            main_clear_s = 1'b1;
            skid_clear_s = 1'b1;
        end else if (!main_valid_s) begin
            main_load_s = accept_s;
        end else if (pop_s) begin
            if (skid_valid_s) begin
                // Older skid entry advances; in_ready was low so no accept
                main_load_s      = 1'b1;
                main_from_skid_s = 1'b1;
                skid_clear_s     = 1'b1;
            end else if (accept_s) begin
                main_load_s = 1'b1;
            end else begin
                main_clear_s = 1'b1;
            end
        end else begin
            // Stalled: a new word parks in the skid slot
            skid_load_s = accept_s;
        end
    end

    assign main_d_pc_s   = main_from_skid_s ? skid_pc_s   : in_pc;
    assign main_d_inst_s = main_from_skid_s ? skid_inst_s : in_inst;

    skid_slot #(.PC_W(PC_W), .INST_W(INST_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load_s),
        .clear  (main_clear_s),
        .d_pc   (main_d_pc_s),
        .d_inst (main_d_inst_s),
        .valid  (main_valid_s),
        .pc     (main_pc_s),
        .inst   (main_inst_s)
    );

    skid_slot #(.PC_W(PC_W), .INST_W(INST_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load_s),
        .clear  (skid_clear_s),
        .d_pc   (in_pc),
        .d_inst (in_inst),
        .valid  (skid_valid_s),
        .pc     (skid_pc_s),
        .inst   (skid_inst_s)
    );

    // Presented word: NOP when idle so all decode fields read as zero
    assign out_pc   = rst ? '0 : main_pc_s;
    assign out_inst = out_valid ? main_inst_s : NOP_INST[INST_W-1:0];

    assign op        = out_inst[OP_HI:OP_LO];
    assign rs        = out_inst[RS_HI:RS_LO];
    assign rt        = out_inst[RT_HI:RT_LO];
    assign rd        = out_inst[RD_HI:RD_LO];
    assign shamt     = out_inst[SHAMT_HI:SHAMT_LO];
    assign funct     = out_inst[FUNCT_HI:FUNCT_LO];
    assign imm_16    = out_inst[IMM_HI:IMM_LO];
    assign target_26 = out_inst[TARGET_HI:TARGET_LO];

`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Stall counter next value: count held-but-unconsumed cycles, wrapping
    always_comb begin
        if (out_valid && !out_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register; flush deliberately does not clear it
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule : if_id_skid_reg

// File: tb/tb_if_id_skid_reg.sv
// Directed self-checking bench for if_id_skid_reg: reset, streaming,
// backpressure through the skid slot, flush, and the optional stall counter.
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm_16;
    logic [25:0] target_26;
`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    if_id_skid_reg dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm_16    (imm_16),
        .target_26 (target_26)
`ifdef IF_ID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock and sample 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        in_valid = v;
        in_pc    = pc;
        in_inst  = inst;
    endtask

    logic [31:0] s_pc   [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] s_inst [3] = '{32'h2008_0005, 32'h3C01_FFFF, 32'h8C22_FFFC};
    logic [15:0] s_imm  [3] = '{16'h0005, 16'hFFFF, 16'hFFFC};
    logic [5:0]  s_op   [3] = '{6'h08, 6'h0F, 6'h23};
    logic [4:0]  s_rt   [3] = '{5'd8, 5'd1, 5'd2};

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 32'h100, 32'hDEAD_BEEF);

        // ---- reset held 3 cycles with in_valid=1
        repeat (3) tick();
        check("rst_in_ready",  in_ready,  1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_inst",  out_inst,  32'h0);
        check("rst_out_pc",    out_pc,    32'h0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // ---- streaming with out_ready=1
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, s_pc[i], s_inst[i]);
            tick();
            check($sformatf("str_valid%0d", i), out_valid, 1'b1);
            check($sformatf("str_pc%0d", i),    out_pc,    s_pc[i]);
            check($sformatf("str_inst%0d", i),  out_inst,  s_inst[i]);
            check($sformatf("str_imm%0d", i),   imm_16,    s_imm[i]);
            check($sformatf("str_op%0d", i),    op,        s_op[i]);
            check($sformatf("str_rt%0d", i),    rt,        s_rt[i]);
        end
        // last word 0x8C22_FFFC: remaining fields
        check("str_rs2",     rs,        5'd1);
        check("str_rd2",     rd,        5'h1F);
        check("str_shamt2",  shamt,     5'h1F);
        check("str_funct2",  funct,     6'h3C);
        check("str_target2", target_26, 26'h022_FFFC);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("str_drain_valid", out_valid, 1'b0);
        check("str_drain_inst",  out_inst,  32'h0);
        check("str_drain_imm",   imm_16,    16'h0);

        // ---- backpressure: 3 words with out_ready=0
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 32'h2409_0001);
        tick();
        check("bp_w1_pc",    out_pc,   32'h10);
        check("bp_w1_ready", in_ready, 1'b1);
        drive(1'b1, 32'h14, 32'h240A_0002);
        tick();
        check("bp_w2_ready", in_ready, 1'b0);
        check("bp_hold_pc",  out_pc,   32'h10);
        drive(1'b1, 32'h18, 32'h240B_0003);
        tick();
        check("bp_w3_ready", in_ready, 1'b0);
        check("bp_hold_inst", out_inst, 32'h2409_0001);
        // pop with skid full while source still offers word 3
        out_ready = 1'b1;
        tick();
        check("bp_skid2main_pc", out_pc,   32'h14);
        check("bp_skid2main_in", out_inst, 32'h240A_0002);
        check("bp_ready_rise",   in_ready, 1'b1);
        tick();
        check("bp_w3_pc",   out_pc,   32'h18);
        check("bp_w3_inst", out_inst, 32'h240B_0003);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("bp_drain_valid", out_valid, 1'b0);

        // ---- flush with main and skid full
        out_ready = 1'b0;
        drive(1'b1, 32'h20, 32'h1111_1111);
        tick();
        drive(1'b1, 32'h24, 32'h2222_2222);
        tick();
        check("fl_full_ready", in_ready, 1'b0);
        flush = 1'b1;
        drive(1'b1, 32'h28, 32'h3333_3333);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("fl_valid", out_valid, 1'b0);
        check("fl_ready", in_ready,  1'b1);
        check("fl_inst",  out_inst,  32'h0);
        tick();
        check("fl_after_valid", out_valid, 1'b0);

        // ---- flush wins over a same-cycle accept and pop
        drive(1'b1, 32'h30, 32'h4444_4444);
        tick();
        check("fl2_loaded", out_pc, 32'h30);
        out_ready = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'h34, 32'h5555_5555);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("fl2_valid", out_valid, 1'b0);
        check("fl2_ready", in_ready,  1'b1);
        tick();
        check("fl2_dropped", out_valid, 1'b0);

`ifdef IF_ID_STALL_CNT_EN
        // ---- stall counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sc_rst0", stall_cnt, 32'd0);
        out_ready = 1'b0;
        drive(1'b1, 32'h40, 32'h6666_6666);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        repeat (7) tick();
        check("sc_seven", stall_cnt, 32'd7);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sc_flush_keep", stall_cnt, 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sc_rst_clear", stall_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_if_id_skid_reg
